// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU request arbiter: FSM state
// encoding, operand field positions and the one-hot status codes.
package fpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Operand layout: sign[31], exponent[30:26], mantissa[25:0]
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 26;
    localparam int MANT_MSB = 25;

    // Status bit positions
    localparam int STATUS_EXACT_BIT     = 0;
    localparam int STATUS_INEXACT_BIT   = 1;
    localparam int STATUS_OVERFLOW_BIT  = 2;
    localparam int STATUS_UNDERFLOW_BIT = 3;

    // One-hot status codes
    localparam logic [3:0] EXACT     = 4'b0001;
    localparam logic [3:0] INEXACT   = 4'b0010;
    localparam logic [3:0] OVERFLOW  = 4'b0100;
    localparam logic [3:0] UNDERFLOW = 4'b1000;

    // Width of the WAIT-state cycle counter
    localparam int TIMER_W = 8;

    // Index of the requester selected by a one-hot 2-way grant
    function automatic logic grant_index(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. The pointer names the requester favoured on
// a tie and moves to the other requester whenever a grant is accepted.
module rr_arbiter2
    import fpu_pkg::*;
(
    input  logic       clock100KHz,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic ptr_q;
    logic ptr_d;

    // Pick a single winner; a lone request wins outright, a tie goes to the pointer
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                grant = ptr_q ? 2'b10 : 2'b01;
            end else begin
                grant = req;
            end
        end
    end

    // After an accepted grant, favour the requester that did not win
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = ~grant_index(grant);
        end
    end

    // Pointer register; reset favours requester 0
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Arbitrates two requesters onto a single external FPU core. One job is in
// flight at a time: accept, pulse fpu_start, wait for done or timeout, then
// hold the response until the consumer takes it.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int STATUS_W       = 4
) (
    input  logic                clock100KHz,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [31:0]         req0_op_a,
    input  logic [31:0]         req0_op_b,
    input  logic [31:0]         req1_op_a,
    input  logic [31:0]         req1_op_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [31:0]         rsp_data,
    output logic [STATUS_W-1:0] rsp_status,
    output logic                rsp_timeout,
    output logic                fpu_start,
    output logic [31:0]         fpu_op_a,
    output logic [31:0]         fpu_op_b,
    input  logic                fpu_done,
    input  logic [31:0]         fpu_data,
    input  logic [STATUS_W-1:0] fpu_status
);

    // Count value seen in the last permitted WAIT cycle (TIMEOUT_CYCLES must be 1..255)
    localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(TIMEOUT_CYCLES - 1);

    arb_state_t          state_q, state_d;
    logic                rsp_id_q, rsp_id_d;
    logic [31:0]         op_a_q, op_a_d;
    logic [31:0]         op_b_q, op_b_d;
    logic                start_q, start_d;
    logic [TIMER_W-1:0]  count_q, count_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_data_q, rsp_data_d;
    logic [STATUS_W-1:0] rsp_status_q, rsp_status_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    logic [1:0] grant;
    logic       accept;

    rr_arbiter2 u_rr_arbiter2 (
        .clock100KHz (clock100KHz),
        .reset       (reset),
        .enable      (state_q == ST_IDLE),
        .req         (req_valid),
        .accept      (accept),
        .grant       (grant)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);

    // Next-state and next-output logic for the job sequencer
    always_comb begin
        state_d       = state_q;
        rsp_id_d      = rsp_id_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        start_d       = 1'b0;
        count_d       = count_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_status_d  = rsp_status_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rsp_id_d = grant_index(grant);
                    op_a_d   = grant_index(grant) ? req1_op_a : req0_op_a;
                    op_b_d   = grant_index(grant) ? req1_op_b : req0_op_b;
                    start_d  = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                count_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fpu_done) begin
                    rsp_data_d    = fpu_data;
                    rsp_status_d  = fpu_status;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else if (count_q == LAST_COUNT) begin
                    rsp_data_d    = '0;
                    rsp_status_d  = '0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else if (count_q != {TIMER_W{1'b1}}) begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight job
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            rsp_id_q      <= 1'b0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            start_q       <= 1'b0;
            count_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_status_q  <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rsp_id_q      <= rsp_id_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            start_q       <= start_d;
            count_q       <= count_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_status_q  <= rsp_status_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign fpu_start   = start_q;
    assign fpu_op_a    = op_a_q;
    assign fpu_op_b    = op_b_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_status  = rsp_status_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Randomized scoreboard bench for fpu_arbiter: two requester drivers, a
// behavioural FPU with chosen latencies, and a monitor that predicts grants
// and responses from the arbitration and timeout rules.
module tb_fpu_arbiter;

    localparam int TIMEOUT      = 255;
    localparam int JOBS_PER_REQ = 20;

    logic        clock100KHz;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_op_a, req0_op_b, req1_op_a, req1_op_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_status;
    logic        rsp_timeout;
    logic        fpu_start;
    logic [31:0] fpu_op_a, fpu_op_b;
    logic        fpu_done;
    logic [31:0] fpu_data;
    logic [3:0]  fpu_status;

    logic        req_v [2];
    logic [31:0] req_a [2];
    logic [31:0] req_b [2];

    assign req_valid = {req_v[1], req_v[0]};
    assign req0_op_a = req_a[0];
    assign req0_op_b = req_b[0];
    assign req1_op_a = req_a[1];
    assign req1_op_b = req_b[1];

    fpu_arbiter #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .STATUS_W       (4)
    ) dut (
        .clock100KHz (clock100KHz),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req0_op_a   (req0_op_a),
        .req0_op_b   (req0_op_b),
        .req1_op_a   (req1_op_a),
        .req1_op_b   (req1_op_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_status  (rsp_status),
        .rsp_timeout (rsp_timeout),
        .fpu_start   (fpu_start),
        .fpu_op_a    (fpu_op_a),
        .fpu_op_b    (fpu_op_b),
        .fpu_done    (fpu_done),
        .fpu_data    (fpu_data),
        .fpu_status  (fpu_status)
    );

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
    } job_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic [3:0]  status;
        logic        timeout;
        int          wait_cycles;
    } rsp_t;

    int   checks_total = 0;
    int   checks_passed = 0;
    int   cyc = 0;

    // Reference model state (owned by the monitor)
    bit   model_busy = 0;
    bit   model_ptr = 0;
    job_t accepted_q[$];
    logic start_ids[$];
    int   start_events = 0;
    int   start_count = 0;
    int   accept_count = 0;
    int   rsp_count = 0;
    int   grants_seen [2] = '{0, 0};
    bit   dut_waiting = 0;
    bit   rsp_seen = 0;
    int   start_cycle = 0;
    logic [31:0] held_a, held_b;
    logic [37:0] held_rsp;

    // Expected responses (pushed by the FPU model, popped by the monitor)
    rsp_t expect_q[$];

    // Stimulus control (owned by the main sequence)
    int   quota [2] = '{0, 0};
    bit   sync_mode = 0;
    bit   force_never = 0;

    // Driver bookkeeping
    int   issued [2] = '{0, 0};
    int   handled [2] = '{0, 0};

    initial clock100KHz = 1'b0;
    always #5 clock100KHz = ~clock100KHz;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " fpu_start"},   fpu_start,   0);
        checkOutput({tag, " fpu_op_a"},    fpu_op_a,    0);
        checkOutput({tag, " fpu_op_b"},    fpu_op_b,    0);
        checkOutput({tag, " rsp_valid"},   rsp_valid,   0);
        checkOutput({tag, " rsp_id"},      rsp_id,      0);
        checkOutput({tag, " rsp_data"},    rsp_data,    0);
        checkOutput({tag, " rsp_status"},  rsp_status,  0);
        checkOutput({tag, " rsp_timeout"}, rsp_timeout, 0);
        checkOutput({tag, " req_ready"},   req_ready,   0);
    endtask

    task automatic applyStimulus(input int i);
        if (i == 0 && issued[0] == 0) begin
            req_a[0] = 32'h0C00_0000;
            req_b[0] = 32'h0C00_0000;
        end else begin
            req_a[i] = $urandom;
            req_b[i] = $urandom;
        end
        req_v[i] = 1'b1;
        issued[i]++;
    endtask

    task automatic boundFail(input string name);
        checks_total++;
        $display("[TB] FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // Cycle counter
    initial begin
        forever begin
            @(posedge clock100KHz);
            cyc++;
        end
    end

    // Requester drivers: hold valid until granted, requester 0 re-raises at once
    initial begin
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        req_a[0] = '0; req_a[1] = '0; req_b[0] = '0; req_b[1] = '0;
        forever begin
            @(posedge clock100KHz);
            #1;
            if (reset !== 1'b1) begin
                req_v[0] = 1'b0;
                req_v[1] = 1'b0;
                handled[0] = grants_seen[0];
                handled[1] = grants_seen[1];
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (req_v[i] && grants_seen[i] != handled[i]) begin
                        handled[i] = grants_seen[i];
                        req_v[i] = 1'b0;
                    end
                end
                if (sync_mode) begin
                    if (!req_v[0] && !req_v[1] && issued[0] < quota[0] && issued[1] < quota[1]) begin
                        applyStimulus(0);
                        applyStimulus(1);
                    end
                end else begin
                    for (int i = 0; i < 2; i++) begin
                        if (!req_v[i] && issued[i] < quota[i] && (i == 0 || $urandom_range(0, 2) != 0)) begin
                            applyStimulus(i);
                        end
                    end
                end
            end
        end
    end

    // Response consumer: random back-pressure with occasional 10-cycle stalls
    initial begin
        int hold;
        hold = 0;
        rsp_ready = 1'b0;
        forever begin
            @(posedge clock100KHz);
            #1;
            if (hold > 0) begin
                rsp_ready = 1'b0;
                hold--;
            end else if ($urandom_range(0, 7) == 0) begin
                rsp_ready = 1'b0;
                hold = 9;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Behavioural FPU: picks a latency per job and predicts the response
    initial begin
        int          remaining;
        int          lat;
        bit          first_job;
        bit          saw_reset;
        int          handled_starts;
        logic [31:0] d;
        logic [3:0]  s;
        rsp_t        e;
        remaining = -1;
        first_job = 1;
        saw_reset = 0;
        handled_starts = 0;
        d = '0;
        s = '0;
        fpu_done = 1'b0;
        fpu_data = '0;
        fpu_status = '0;
        forever begin
            @(posedge clock100KHz);
            #1;
            fpu_done = 1'b0;
            fpu_data = $urandom;
            fpu_status = 4'($urandom);
            if (reset !== 1'b1) begin
                remaining = -1;
                handled_starts = start_events;
                saw_reset = (cyc > 10);
            end else begin
                if (saw_reset) begin
                    saw_reset = 0;
                    fpu_done = 1'b1;
                end else if (start_events != handled_starts) begin
                    handled_starts = start_events;
                    if (first_job) begin
                        first_job = 0;
                        lat = 3;
                        d = 32'h1000_0000;
                        s = 4'b0001;
                    end else begin
                        d = $urandom;
                        s = 4'b0001 << $urandom_range(0, 3);
                        if (force_never) begin
                            lat = -1;
                        end else begin
                            case ($urandom_range(0, 15))
                                0:       lat = -1;
                                1:       lat = TIMEOUT;
                                2:       lat = TIMEOUT + 1;
                                default: lat = $urandom_range(1, 6);
                            endcase
                        end
                    end
                    e.id = (start_ids.size() > 0) ? start_ids.pop_front() : 1'b0;
                    if (lat >= 1 && lat <= TIMEOUT) begin
                        e.data = d;
                        e.status = s;
                        e.timeout = 1'b0;
                        e.wait_cycles = lat;
                    end else begin
                        e.data = '0;
                        e.status = '0;
                        e.timeout = 1'b1;
                        e.wait_cycles = TIMEOUT;
                    end
                    expect_q.push_back(e);
                    remaining = lat;
                end
                if (remaining > 0) begin
                    remaining--;
                    if (remaining == 0) begin
                        fpu_done = 1'b1;
                        fpu_data = d;
                        fpu_status = s;
                        remaining = -1;
                    end
                end else if (!dut_waiting && $urandom_range(0, 4) == 0) begin
                    fpu_done = 1'b1;
                end
            end
        end
    end

    // Monitor: predicts grants, checks FPU issue and pops the scoreboard on responses
    initial begin
        logic [1:0] exp_ready;
        job_t       job;
        rsp_t       e;
        forever begin
            @(negedge clock100KHz);
            if (reset !== 1'b1) begin
                model_busy = 0;
                model_ptr = 0;
                accepted_q.delete();
                expect_q.delete();
                start_ids.delete();
                rsp_seen = 0;
                dut_waiting = 0;
            end else begin
                exp_ready = 2'b00;
                if (!model_busy && req_valid != 2'b00) begin
                    if (req_valid == 2'b11) exp_ready = model_ptr ? 2'b10 : 2'b01;
                    else                    exp_ready = req_valid;
                end
                checkOutput("req_ready", req_ready, exp_ready);
                if (exp_ready != 2'b00) begin
                    job.id = exp_ready[1];
                    job.a  = exp_ready[1] ? req1_op_a : req0_op_a;
                    job.b  = exp_ready[1] ? req1_op_b : req0_op_b;
                    accepted_q.push_back(job);
                    model_busy = 1;
                    model_ptr = ~exp_ready[1];
                    accept_count++;
                    grants_seen[exp_ready[1]]++;
                end

                if (fpu_start) begin
                    start_count++;
                    if (accepted_q.size() == 0) begin
                        boundFail("fpu_start without accepted job");
                    end else begin
                        job = accepted_q.pop_front();
                        checkOutput("fpu_op_a at start", fpu_op_a, job.a);
                        checkOutput("fpu_op_b at start", fpu_op_b, job.b);
                        start_ids.push_back(job.id);
                        held_a = job.a;
                        held_b = job.b;
                        start_cycle = cyc + 1;
                        dut_waiting = 1;
                        start_events++;
                    end
                end else if (dut_waiting) begin
                    checkOutput("fpu_op_a stable", fpu_op_a, held_a);
                    checkOutput("fpu_op_b stable", fpu_op_b, held_b);
                end

                if (rsp_valid) begin
                    if (!rsp_seen) begin
                        dut_waiting = 0;
                        rsp_seen = 1;
                        rsp_count++;
                        held_rsp = {rsp_id, rsp_data, rsp_status, rsp_timeout};
                        if (expect_q.size() == 0) begin
                            boundFail("rsp_valid without expected response");
                        end else begin
                            e = expect_q.pop_front();
                            checkOutput("rsp_id", rsp_id, e.id);
                            checkOutput("rsp_data", rsp_data, e.data);
                            checkOutput("rsp_status", rsp_status, e.status);
                            checkOutput("rsp_timeout", rsp_timeout, e.timeout);
                            checkOutput("wait cycles", cyc - start_cycle, e.wait_cycles);
                        end
                    end else begin
                        checkOutput("rsp fields held", {rsp_id, rsp_data, rsp_status, rsp_timeout}, held_rsp);
                    end
                    if (rsp_ready) begin
                        rsp_seen = 0;
                        model_busy = 0;
                    end
                end
            end
        end
    end

    // Main sequence: reset, tie after reset, random traffic, mid-flight reset
    initial begin
        int n;
        bit done;
        reset = 1'b0;
        #1;
        checkResetValues("reset async");
        repeat (3) @(posedge clock100KHz);
        #3;
        checkResetValues("reset held");
        sync_mode = 1;
        quota[0] = 1;
        quota[1] = 1;
        reset = 1'b1;

        done = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clock100KHz);
            done = (issued[0] == 1 && issued[1] == 1);
        end
        if (!done) boundFail("initial tie issue");
        sync_mode = 0;
        quota[0] = JOBS_PER_REQ + 1;
        quota[1] = JOBS_PER_REQ + 1;

        done = 0;
        for (int k = 0; k < 40000 && !done; k++) begin
            @(negedge clock100KHz);
            done = (issued[0] == quota[0] && issued[1] == quota[1] && !req_v[0] && !req_v[1]
                    && !model_busy && expect_q.size() == 0);
        end
        if (!done) boundFail("random traffic drain");

        force_never = 1;
        quota[1] = quota[1] + 1;
        done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clock100KHz);
            done = dut_waiting;
        end
        if (!done) boundFail("reach WAIT before reset");
        repeat (5) @(posedge clock100KHz);
        #3;
        reset = 1'b0;
        #1;
        checkResetValues("mid-flight reset");
        @(posedge clock100KHz);
        #3;
        reset = 1'b1;
        force_never = 0;

        n = 0;
        repeat (20) begin
            @(negedge clock100KHz);
            if (rsp_valid) n++;
        end
        checkOutput("rsp_valid cycles after reset", n, 0);

        sync_mode = 1;
        quota[0] = quota[0] + 1;
        quota[1] = quota[1] + 1;
        done = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clock100KHz);
            done = (issued[0] == quota[0] && issued[1] == quota[1] && !req_v[0] && !req_v[1]
                    && !model_busy && expect_q.size() == 0);
        end
        if (!done) boundFail("post-reset drain");

        checkOutput("fpu_start pulses vs accepts", start_count, accept_count);
        checkOutput("responses vs accepts", rsp_count, accept_count - 1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
